// File: rtl/uart_recv.sv
// uart_recv -- 8N1 UART receiver (start 0, 8 data bits LSB first, stop 1).
// Counterpart of uart_send: same clock and baud parameters, so uart_send's
// dout can wire straight to din.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   din        asynchronous serial line, idle high
//   data       last correctly framed byte, held until the next good frame
//   valid      one-cycle pulse, data updated this cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       high whenever the receiver is not idle
//
// Optional build macro UART_RX_MAJORITY_EN: every sample (start, data, stop)
// becomes the 2-of-3 majority of rx at target-1, target and target+1. The
// decision lands one cycle later; bit-to-bit spacing is unchanged.
module uart_recv #(
  parameter int CLOCK_FREQ  = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int BIT_CYCLES  = CLOCK_FREQ / BAUD_RATE,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BIT_CYCLES + 1);

`ifdef UART_RX_MAJORITY_EN
  // Decision one cycle past the nominal sample point. After a decision the
  // counter reloads to 1 because that cycle already belongs to the next bit.
  localparam logic [CW-1:0] START_AT = CW'(HALF_CYCLES);
  localparam logic [CW-1:0] BIT_AT   = CW'(BIT_CYCLES);
  localparam logic [CW-1:0] RELOAD   = CW'(1);
`else
  localparam logic [CW-1:0] START_AT = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] BIT_AT   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] RELOAD   = '0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rx;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shift;
  logic          at_sample;
  logic          bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic          smp_a;
  logic          smp_b;
  logic          cap_a;
  logic          cap_b;

  always_comb begin
    if (state == START) begin
      at_sample = (cnt == START_AT);
      cap_a     = (cnt == START_AT - CW'(2));
      cap_b     = (cnt == START_AT - CW'(1));
    end else begin
      at_sample = (cnt == BIT_AT);
      cap_a     = (cnt == BIT_AT - CW'(2));
      cap_b     = (cnt == BIT_AT - CW'(1));
    end
    bit_val = (smp_a & smp_b) | (smp_a & rx) | (smp_b & rx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      if (cap_a) smp_a <= rx;
      if (cap_b) smp_b <= rx;
    end
  end
`else
  always_comb begin
    at_sample = (state == START) ? (cnt == START_AT) : (cnt == BIT_AT);
    bit_val   = rx;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      rx        <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync1     <= din;
      rx        <= sync1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (at_sample) begin
            if (bit_val) begin
              // Line back high at mid start bit: glitch, not a frame.
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= RELOAD;
              bidx  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (at_sample) begin
            shift[bidx] <= bit_val;
            bidx        <= bidx + 3'd1;
            cnt         <= RELOAD;
            if (bidx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (at_sample) begin
            cnt <= '0;
            if (bit_val) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Hold off until the line returns high so a held-low line
          // does not retrigger a new frame.
          if (rx) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv -- directed testbench for uart_recv with a 16-cycle bit
// period (CLOCK_FREQ 160, BAUD_RATE 10, HALF_CYCLES 8).
module tb_uart_recv;

  localparam int BIT  = 16;
  localparam int HALF = 8;
  localparam int LAT  = 9 * BIT + HALF + 3;  // 9.5 bits + 3 = 155

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_recv #(
    .CLOCK_FREQ(160),
    .BAUD_RATE (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         inv_err   = 0;
  int         post_err  = 0;
  int         valid_t[$];
  logic [7:0] valid_d[$];
  logic       busy_prev  = 1'b0;
  logic       valid_prev = 1'b0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      valid_t.push_back(cyc);
      valid_d.push_back(data);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if ((valid === 1'b1 && frame_err === 1'b1) ||
        ((valid === 1'b1 || frame_err === 1'b1) && busy_prev !== 1'b1))
      inv_err++;
    if (valid_prev === 1'b1 && busy !== 1'b0) post_err++;
    busy_prev  = busy;
    valid_prev = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    din = b;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT);
    send_bit(1'b1, BIT);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    repeat (3) tick();
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int v0, f0, t0, lat;
    v0 = valid_cnt; f0 = ferr_cnt; t0 = cyc;
    send_frame(8'hA5);
    send_bit(1'b1, BIT);
    tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL single_count: got %0d expected 1", valid_cnt - v0); end
    tests++; if (data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", data); end
    tests++; if (ferr_cnt !== f0) begin fails++; $display("FAIL single_ferr: got %0d expected %0d", ferr_cnt, f0); end
    lat = (valid_t.size() > 0) ? valid_t[valid_t.size()-1] - t0 : -1;
    tests++; if (lat < LAT - 1 || lat > LAT + 1) begin fails++; $display("FAIL single_latency: got %0d expected %0d+-1", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int v0, f0, n, gap;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C);
    send_frame(8'hFF);
    send_bit(1'b1, BIT);
    n = valid_d.size();
    tests++; if (valid_cnt - v0 !== 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - v0); end
    if (n >= 2) begin
      tests++; if (valid_d[n-2] !== 8'h3C) begin fails++; $display("FAIL b2b_first: got %h expected 3c", valid_d[n-2]); end
      tests++; if (valid_d[n-1] !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h expected ff", valid_d[n-1]); end
      gap = valid_t[n-1] - valid_t[n-2];
      tests++; if (gap < 10*BIT - 1 || gap > 10*BIT + 1) begin fails++; $display("FAIL b2b_gap: got %0d expected %0d+-1", gap, 10*BIT); end
    end
    tests++; if (ferr_cnt !== f0) begin fails++; $display("FAIL b2b_ferr: got %0d expected %0d", ferr_cnt, f0); end
  endtask

  task automatic test_false_start();
    int v0, f0;
    logic [7:0] d0;
    v0 = valid_cnt; f0 = ferr_cnt; d0 = data;
    din = 1'b0;
    repeat (BIT/4) tick();
    din = 1'b1;
    repeat (2) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL false_busy_hi: got %b expected 1", busy); end
    repeat (14) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL false_busy_lo: got %b expected 0", busy); end
    tests++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin fails++; $display("FAIL false_pulses: got v=%0d f=%0d expected v=%0d f=%0d", valid_cnt, ferr_cnt, v0, f0); end
    tests++; if (data !== d0) begin fails++; $display("FAIL false_data: got %h expected %h", data, d0); end
    send_bit(1'b1, BIT);
  endtask

  task automatic test_break();
    int v0, f0;
    logic [7:0] d0;
    v0 = valid_cnt; f0 = ferr_cnt; d0 = data;
    send_bit(1'b0, 9*BIT);       // start + data 0x00
    send_bit(1'b0, 20*BIT);      // stop bit and beyond held low
    tests++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL break_ferr: got %0d expected 1", ferr_cnt - f0); end
    tests++; if (valid_cnt !== v0) begin fails++; $display("FAIL break_valid: got %0d expected %0d", valid_cnt, v0); end
    tests++; if (data !== d0) begin fails++; $display("FAIL break_data: got %h expected %h", data, d0); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL break_busy_hi: got %b expected 1", busy); end
    din = 1'b1;
    repeat (4) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL break_busy_lo: got %b expected 0", busy); end
    send_bit(1'b1, BIT);
    v0 = valid_cnt;
    send_frame(8'h5A);
    send_bit(1'b1, BIT);
    tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL break_next_count: got %0d expected 1", valid_cnt - v0); end
    tests++; if (data !== 8'h5A) begin fails++; $display("FAIL break_next_data: got %h expected 5a", data); end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    logic [7:0] b;
    b = 8'hA5;
    send_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(b[i], BIT);
    din = b[4];
    repeat (HALF) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h expected 00", data); end
    tests++; if (valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL rstmid_ctl: got v=%b b=%b f=%b expected 0 0 0", valid, busy, frame_err); end
    v0 = valid_cnt; f0 = ferr_cnt;
    repeat (BIT - HALF - 1) tick();
    for (int i = 5; i < 8; i++) send_bit(b[i], BIT);
    send_bit(1'b1, BIT);
    tests++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin fails++; $display("FAIL rstmid_tail: got v=%0d f=%0d expected v=%0d f=%0d", valid_cnt, ferr_cnt, v0, f0); end
    // A low data bit after the reset looks like a new start edge; let
    // whatever it starts run out before the clean frame.
    send_bit(1'b1, 12*BIT);
    send_frame(8'h5A);
    send_bit(1'b1, BIT);
    tests++; if (data !== 8'h5A) begin fails++; $display("FAIL rstmid_next: got %h expected 5a", data); end
  endtask

  task automatic test_glitch();
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'hFF;
`else
    exp_d = 8'hF7;
`endif
    send_bit(1'b0, BIT);
    for (int i = 0; i < 3; i++) send_bit(1'b1, BIT);
    din = 1'b1;
    repeat (HALF) tick();
    din = 1'b0;
    tick();
    din = 1'b1;
    repeat (BIT - HALF - 1) tick();
    for (int i = 4; i < 8; i++) send_bit(1'b1, BIT);
    send_bit(1'b1, BIT);
    send_bit(1'b1, BIT);
    tests++; if (data !== exp_d) begin fails++; $display("FAIL glitch_data: got %h expected %h", data, exp_d); end
  endtask

  task automatic test_invariants();
    tests++; if (inv_err !== 0) begin fails++; $display("FAIL pulse_rules: got %0d violations expected 0", inv_err); end
    tests++; if (post_err !== 0) begin fails++; $display("FAIL busy_after_valid: got %0d violations expected 0", post_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_break();
    test_reset_mid();
    test_glitch();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver: 8N1 frames (start 0, 8 data bits LSB first, stop 1), idle line high.
- Counterpart of uart_send. Same clock, same baud parameters, so uart_send dout wires straight to uart_recv din.
- Presents each received byte with a one-cycle valid pulse and flags framing errors.

Parameters:
- CLOCK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- BIT_CYCLES, CLOCK_FREQ/BAUD_RATE (10416 at default), clock cycles per bit, integer division.
- HALF_CYCLES, BIT_CYCLES/2 (5208 at default), cycles from start-edge detection to the start-bit sample point.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  asynchronous serial line, idle high.
- data  output  8  last correctly framed byte, held until the next good frame.
- valid  output  1  one-cycle pulse: data updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- busy  output  1  high while in any state other than IDLE.

Behaviour:
- Reset values: data=8'h00, valid=0, frame_err=0, busy=0. Synchronizer flops=1, state=IDLE, counters=0.
- din passes through a 2-flop synchronizer; all decisions use the synchronized value rx.
- Single cycle counter cnt, 0..BIT_CYCLES-1, cleared on every state change. Bit index bidx, 0..7.
- IDLE: rx==0 -> START, cnt=0. Otherwise stay.
- START: at cnt==HALF_CYCLES-1, sample rx.
  - rx==1: false start, -> IDLE with no output pulse.
  - rx==0: -> DATA, cnt=0, bidx=0.
- DATA: at cnt==BIT_CYCLES-1, sample rx into shift[bidx] (LSB first). bidx increments.
  - After bidx==7 is sampled -> STOP.
  - Every sample lands at the bit centre.
- STOP: at cnt==BIT_CYCLES-1, sample rx.
  - rx==1: data<=shift, valid=1 for exactly one cycle, -> IDLE.
  - rx==0: frame_err=1 for one cycle, data unchanged, -> BREAK.
- BREAK: wait until rx==1, then -> IDLE. This prevents re-triggering on a held-low line.
- Latency: valid rises mid-stop-bit, i.e. 9.5*BIT_CYCLES + 3 cycles (±1) after the din falling edge.
- Back-to-back frames: IDLE is re-entered half a bit before the next start edge, so zero-gap frames are received.
- valid and frame_err are never high in the same cycle. Neither is high when busy was 0 the previous cycle.
- Reset mid-frame: aborts immediately. Partial byte discarded, all outputs to reset values. The next falling edge starts a fresh frame.
- No flow control. Consumer must take data on the valid cycle; data is stable until the next valid.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each sample (start, data, stop) is the 2-of-3 majority of rx at cnt target-1, target, target+1. The decision is applied at target+1; all other timing is unchanged. A single-cycle glitch at a sample point is rejected.
- Undefined: single sample of rx at the target cycle.

Test Plan:
- Drive 8N1 frame 0xA5 at BIT_CYCLES per bit -> exactly one valid pulse, data=8'hA5, frame_err stays 0. valid occurs 9.5*BIT_CYCLES+3 (±1) cycles after the start edge. busy returns 0 the cycle after valid.
- Two frames 0x3C then 0xFF, zero idle gap -> two valid pulses exactly 10*BIT_CYCLES (±1) apart, data=8'h3C then 8'hFF, no frame_err.
- din low for BIT_CYCLES/4 then high -> no valid, no frame_err, busy high for about HALF_CYCLES then 0, data unchanged.
- Start bit, data 0x00, then line held low for 20 bit periods -> one frame_err pulse, no valid, data keeps the prior value, busy stays 1 until din rises. Following frame 0x5A -> valid, data=8'h5A.
- rst asserted for 1 cycle during data bit 4 of frame 0xA5 -> next cycle data=0, valid=0, busy=0. The remaining bits cause no output. Subsequent clean frame 0x5A -> data=8'h5A.
- Frame 0xFF with a 1-cycle low glitch on din aligned to the bit-3 sample point -> with UART_RX_MAJORITY_EN data=8'hFF; without it data=8'hF7.
